// File: rtl/grad_weight_div.sv
// grad_weight_div
//   Directional blending weights for the CFA G-channel interpolation path.
//   Takes a guarded gradient pair and computes, with a restoring divider that
//   produces one quotient bit per clock:
//      w_h = floor(grad_v * 2^frac / (grad_h + grad_v))   (unsigned Q1.frac)
//      w_v = 2^frac - w_h
//   A zero gradient sum bypasses the divider and yields w_h = w_v = 0.5 with
//   sum_zero raised.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   grad_h, grad_v        guarded gradients, bitwidth bits unsigned
//   in_tag                sideband carried unchanged to out_tag
//   out_valid / out_ready result handshake; outputs hold while stalled
//   w_h, w_v              weights, frac+1 bits, always sum to 2^frac
//   out_tag               tag captured with the pair
//   sum_zero              captured grad_h + grad_v was zero
module grad_weight_div #(
   parameter int bitwidth = 16,
   parameter int frac     = 8,
   parameter int tagw     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [bitwidth-1:0] grad_h,
   input  logic [bitwidth-1:0] grad_v,
   input  logic [tagw-1:0]     in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [frac:0]       w_h,
   output logic [frac:0]       w_v,
   output logic [tagw-1:0]     out_tag,
   output logic                sum_zero
);

   localparam int cntw = $clog2(frac + 1);

   // 1.0 and 0.5 in Q1.frac
   localparam logic [frac:0] one_w  = {1'b1, {frac{1'b0}}};
   localparam logic [frac:0] half_w = {2'b01, {(frac - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_r;
   logic [bitwidth:0]     sum_r;      // grad_h + grad_v, one spare bit
   logic [bitwidth-1:0]   gv_r;
   logic [tagw-1:0]       tag_r;
   logic [bitwidth+1:0]   rem_r;      // remainder; 2R of a value < sum still fits
   logic [frac:0]         q_r;
   logic [cntw-1:0]       cnt_r;
   logic                  first_r;    // first CALC cycle computes the integer bit

   logic [bitwidth+1:0]   sum_ext_s;
   logic [bitwidth+1:0]   gv_ext_s;
   logic [bitwidth+1:0]   rem_dbl_s;
   logic [bitwidth+1:0]   rem_next_s;
   logic [bitwidth+1:0]   rem_first_s;
   logic                  bit_s;
   logic                  msb_s;
   logic [frac:0]         q_next_s;

   // One restoring-division step, plus the integer-bit step of the first cycle
   always_comb begin
      sum_ext_s   = {1'b0, sum_r};
      gv_ext_s    = {2'b00, gv_r};
      // rem_r < sum_r, so its top bit is always zero and can be shifted out
      rem_dbl_s   = {rem_r[bitwidth:0], 1'b0};
      bit_s       = 1'b0;
      rem_next_s  = rem_dbl_s;
      msb_s       = 1'b0;
      rem_first_s = gv_ext_s;
      if (rem_dbl_s >= sum_ext_s) begin
         bit_s      = 1'b1;
         rem_next_s = rem_dbl_s - sum_ext_s;
      end else begin
         bit_s      = 1'b0;
         rem_next_s = rem_dbl_s;
      end
      if (gv_ext_s >= sum_ext_s) begin
         msb_s       = 1'b1;
         rem_first_s = gv_ext_s - sum_ext_s;
      end else begin
         msb_s       = 1'b0;
         rem_first_s = gv_ext_s;
      end
      q_next_s = {q_r[frac-1:0], bit_s};
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         w_h       <= '0;
         w_v       <= '0;
         out_tag   <= '0;
         sum_zero  <= 1'b0;
         sum_r     <= '0;
         gv_r      <= '0;
         tag_r     <= '0;
         rem_r     <= '0;
         q_r       <= '0;
         cnt_r     <= '0;
         first_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sum_r    <= {1'b0, grad_h} + {1'b0, grad_v};
                  gv_r     <= grad_v;
                  tag_r    <= in_tag;
                  cnt_r    <= cntw'(frac);
                  first_r  <= 1'b1;
                  in_ready <= 1'b0;
                  state_r  <= CALC;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               if (sum_r == {(bitwidth + 1){1'b0}}) begin
                  w_h       <= half_w;
                  w_v       <= half_w;
                  sum_zero  <= 1'b1;
                  out_tag   <= tag_r;
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end else if (first_r) begin
                  q_r     <= {{frac{1'b0}}, msb_s};
                  rem_r   <= rem_first_s;
                  first_r <= 1'b0;
               end else begin
                  q_r   <= q_next_s;
                  rem_r <= rem_next_s;
                  cnt_r <= cnt_r - cntw'(1);
                  // last fractional bit lands this cycle
                  if (cnt_r == cntw'(1)) begin
                     w_h       <= q_next_s;
                     w_v       <= one_w - q_next_s;
                     sum_zero  <= 1'b0;
                     out_tag   <= tag_r;
                     out_valid <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     out_valid <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grad_weight_div.sv
// Self-checking bench for grad_weight_div: directed cases, reset abort,
// backpressure and a random stream checked against an arithmetic model.
module tb_grad_weight_div;

   localparam int BW   = 16;
   localparam int FRAC = 8;
   localparam int TW   = 8;
   localparam int ONE  = 1 << FRAC;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [BW-1:0]   grad_h;
   logic [BW-1:0]   grad_v;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [FRAC:0]   w_h;
   logic [FRAC:0]   w_v;
   logic [TW-1:0]   out_tag;
   logic            sum_zero;

   int n_tests = 0;
   int n_fail  = 0;

   grad_weight_div #(.bitwidth(BW), .frac(FRAC), .tagw(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .grad_h    (grad_h),
      .grad_v    (grad_v),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .w_h       (w_h),
      .w_v       (w_v),
      .out_tag   (out_tag),
      .sum_zero  (sum_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: weights straight from the defining ratio
   function automatic void ref_model(input longint gh, input longint gv,
                                     output longint eh, output longint ev,
                                     output longint ez, output longint elat);
      if (gh + gv == 0) begin
         eh = ONE / 2; ev = ONE / 2; ez = 1; elat = 1;
      end else begin
         eh = (gv * ONE) / (gh + gv);
         ev = ONE - eh; ez = 0; elat = FRAC + 1;
      end
   endfunction

   // Push one pair, wait for the result, stall it for `hold` cycles, then drain
   task automatic do_pair(input int gh, input int gv, input int tg, input int hold);
      longint eh, ev, ez, elat;
      int k;
      int edges;
      ref_model(gh, gv, eh, ev, ez, elat);
      @(negedge clk);
      grad_h    = BW'(gh);
      grad_v    = BW'(gv);
      in_tag    = TW'(tg);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check_eq("accept_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      grad_h   = BW'($urandom);
      grad_v   = BW'($urandom);
      in_tag   = TW'($urandom);
      edges = 0;
      while (!out_valid && edges < 50) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check_eq("latency", edges, elat);
      check_eq("w_h", w_h, eh);
      check_eq("w_v", w_v, ev);
      check_eq("invariant", longint'(w_h) + longint'(w_v), ONE);
      check_eq("out_tag", out_tag, tg);
      check_eq("sum_zero", sum_zero, ez);
      check_eq("busy_ready", in_ready, 0);
      // stalled consumer with an eager producer: nothing may move
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         grad_h   = BW'($urandom);
         grad_v   = BW'($urandom);
         @(posedge clk);
         #1;
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_w_h", w_h, eh);
         check_eq("hold_tag", out_tag, tg);
         check_eq("hold_ready", in_ready, 0);
      end
      // handshake edge; a pair presented now must not be taken yet
      in_valid  = (hold > 0) ? 1'b1 : 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("drain_valid", out_valid, 0);
      check_eq("drain_ready", in_ready, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int ghs[8];
      int gvs[8];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      grad_h    = '0;
      grad_v    = '0;
      in_tag    = '0;
      #12;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_w_h", w_h, 0);
      check_eq("rst_w_v", w_v, 0);
      check_eq("rst_out_tag", out_tag, 0);
      check_eq("rst_sum_zero", sum_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed cases from the datasheet examples and boundaries
      ghs = '{1, 1, 3, 0, 7, 65535, 0, 100};
      gvs = '{1, 2, 1, 5, 0, 65535, 0, 300};
      for (int i = 0; i < 8; i++) do_pair(ghs[i], gvs[i], 8'h30 + i, 0);

      // long backpressure on an ordinary pair and on a zero-sum pair
      do_pair(1, 2, 8'hA5, 20);
      do_pair(0, 0, 8'h5A, 3);

      // reset in the middle of a division aborts it asynchronously
      @(negedge clk);
      grad_h   = 16'd5;
      grad_v   = 16'd9;
      in_tag   = 8'hEE;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_out_valid", out_valid, 0);
      check_eq("abort_w_h", w_h, 0);
      check_eq("abort_w_v", w_v, 0);
      check_eq("abort_sum_zero", sum_zero, 0);
      check_eq("abort_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check_eq("abort_no_result", out_valid, 0);
      check_eq("abort_ready_after", in_ready, 1);
      do_pair(5, 9, 8'h77, 0);

      // random stream; small ranges hit zeros and equal values often
      for (int i = 0; i < 1000; i++) begin
         int gh;
         int gv;
         case ($urandom_range(0, 3))
            0: begin gh = $urandom_range(0, 3); gv = $urandom_range(0, 3); end
            1: begin gh = $urandom_range(0, 65535); gv = $urandom_range(0, 15); end
            2: begin gh = $urandom_range(65000, 65535); gv = $urandom_range(65000, 65535); end
            default: begin gh = $urandom_range(0, 65535); gv = $urandom_range(0, 65535); end
         endcase
         do_pair(gh, gv, $urandom_range(0, 255), $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
